// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg: shared types and constants for the UART image link.
// FSM state encodings, preamble byte values and bit-period helper.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        PRE_HUNT,
        PRE_GOT55,
        PRE_IMG
    } pre_state_t;

    localparam logic [7:0] PRE0 = 8'h55;
    localparam logic [7:0] PRE1 = 8'hAA;

    function automatic int bit_cycles(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/uart_img_link_if.sv
`timescale 1ns/1ps
// uart_img_link_if: MCU-side register/handshake bundle of the UART link.
// slave = the link itself, master = the MCU logic driving rd/wr.
interface uart_img_link_if;
    logic [7:0] rx_data;
    logic       rx_full;
    logic       rd;
    logic       overrun;
    logic       frame_err;
    logic [7:0] tx_data;
    logic       wr;
    logic       tx_ready;
    logic       img_recv;
    logic       end_img_recv;

    modport master (
        input  rx_data, rx_full, overrun, frame_err, tx_ready, img_recv,
        output rd, tx_data, wr, end_img_recv
    );

    modport slave (
        output rx_data, rx_full, overrun, frame_err, tx_ready, img_recv,
        input  rd, tx_data, wr, end_img_recv
    );
endinterface

// File: rtl/uart_tx_ser.sv
`timescale 1ns/1ps
// uart_tx_ser: 8N1 serializer with its own bit timer.
// tx is registered so the line never glitches; ready means idle.
module uart_tx_ser
    import uart_pkg::*;
#(
    parameter int BIT_CYC   = 234,
    parameter int TIM_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);
    localparam logic [TIM_WIDTH-1:0] BIT_M1 = TIM_WIDTH'(BIT_CYC - 1);

    tx_state_t            state, state_n;
    logic [TIM_WIDTH-1:0] tim, tim_n;
    logic [7:0]           sh, sh_n;
    logic [2:0]           cnt, cnt_n;
    logic                 tx_n;
    logic                 expire;

    assign expire = (tim == '0);
    assign ready  = (state == TX_IDLE);

    // State, timer, shifter and line register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TX_IDLE;
            tim   <= '0;
            sh    <= '0;
            cnt   <= '0;
            tx    <= 1'b1;
        end else begin
            state <= state_n;
            tim   <= tim_n;
            sh    <= sh_n;
            cnt   <= cnt_n;
            tx    <= tx_n;
        end
    end

    // Next state: start bit, 8 data bits LSB first, stop bit.
    always_comb begin
        state_n = state;
        tim_n   = tim;
        sh_n    = sh;
        cnt_n   = cnt;
        tx_n    = tx;
        unique case (state)
            TX_IDLE: begin
                if (wr) begin
                    state_n = TX_START;
                    sh_n    = data;
                    tim_n   = BIT_M1;
                    tx_n    = 1'b0;
                end
            end
            TX_START: begin
                if (expire) begin
                    state_n = TX_DATA;
                    tim_n   = BIT_M1;
                    cnt_n   = '0;
                    tx_n    = sh[0];
                end else begin
                    tim_n = tim - 1'b1;
                end
            end
            TX_DATA: begin
                if (expire) begin
                    tim_n = BIT_M1;
                    if (cnt == 3'd7) begin
                        state_n = TX_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        sh_n  = {1'b0, sh[7:1]};
                        cnt_n = cnt + 3'd1;
                        tx_n  = sh[1];
                    end
                end else begin
                    tim_n = tim - 1'b1;
                end
            end
            TX_STOP: begin
                if (expire) begin
                    state_n = TX_IDLE;
                end else begin
                    tim_n = tim - 1'b1;
                end
            end
        endcase
    end
endmodule

// File: rtl/uart_img_link.sv
`timescale 1ns/1ps
// uart_img_link: 8N1 UART endpoint with memory-image preamble detector.
// RX and 55/AA detector live here; TX is delegated to uart_tx_ser.
module uart_img_link
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ  = 27_000_000,
    parameter int BAUD      = 115200,
    parameter int TIM_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    output logic            tx,
    uart_img_link_if.slave  bus
);
    localparam int BIT_CYC = bit_cycles(CLOCK_HZ, BAUD);
    localparam logic [TIM_WIDTH-1:0] BIT_M1  = TIM_WIDTH'(BIT_CYC - 1);
    localparam logic [TIM_WIDTH-1:0] HALF_M1 = TIM_WIDTH'(BIT_CYC / 2 - 1);

    logic                 sync1, rxs;
    rx_state_t            state, state_n;
    pre_state_t           pre, pre_n;
    logic [TIM_WIDTH-1:0] tim, tim_n;
    logic [7:0]           sh, sh_n;
    logic [2:0]           cnt, cnt_n;
    logic                 expire, done, bad, hit;
    logic [7:0]           rx_data;
    logic                 rx_full, overrun, frame_err, img_recv;

    assign expire        = (tim == '0);
    assign bus.rx_data   = rx_data;
    assign bus.rx_full   = rx_full;
    assign bus.overrun   = overrun;
    assign bus.frame_err = frame_err;
    assign bus.img_recv  = img_recv;

    // Two-flop synchronizer; idles high so reset looks like a quiet line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    // RX and detector state registers plus bit timer/shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RX_IDLE;
            pre   <= PRE_HUNT;
            tim   <= '0;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            pre   <= pre_n;
            tim   <= tim_n;
            sh    <= sh_n;
            cnt   <= cnt_n;
        end
    end

    // RX next state: half-bit to mid start, then whole bits to mid data/stop.
    always_comb begin
        state_n = state;
        tim_n   = tim;
        sh_n    = sh;
        cnt_n   = cnt;
        done    = 1'b0;
        bad     = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (!rxs) begin
                    state_n = RX_START;
                    tim_n   = HALF_M1;
                end
            end
            RX_START: begin
                if (expire) begin
                    if (rxs) begin
                        state_n = RX_IDLE;
                    end else begin
                        state_n = RX_DATA;
                        tim_n   = BIT_M1;
                        cnt_n   = '0;
                    end
                end else begin
                    tim_n = tim - 1'b1;
                end
            end
            RX_DATA: begin
                if (expire) begin
                    sh_n  = {rxs, sh[7:1]};
                    tim_n = BIT_M1;
                    if (cnt == 3'd7) begin
                        state_n = RX_STOP;
                    end else begin
                        cnt_n = cnt + 3'd1;
                    end
                end else begin
                    tim_n = tim - 1'b1;
                end
            end
            RX_STOP: begin
                if (expire) begin
                    state_n = RX_IDLE;
                    done    = rxs;
                    bad     = !rxs;
                end else begin
                    tim_n = tim - 1'b1;
                end
            end
        endcase
    end

    // Preamble detector: advances only on accepted bytes; framing error re-hunts.
    always_comb begin
        pre_n = pre;
        hit   = 1'b0;
        if (bad) begin
            pre_n = PRE_HUNT;
        end else if (pre == PRE_IMG) begin
            if (bus.end_img_recv) pre_n = PRE_HUNT;
        end else if (done) begin
            if (pre == PRE_GOT55 && sh == PRE1) begin
                pre_n = PRE_IMG;
                hit   = 1'b1;
            end else if (sh == PRE0) begin
                pre_n = PRE_GOT55;
            end else begin
                pre_n = PRE_HUNT;
            end
        end
    end

    // Receive flags: a completing byte wins over a same-cycle rd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= '0;
            rx_full   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            img_recv  <= 1'b0;
        end else begin
            frame_err <= bad;
            img_recv  <= hit;
            if (done) begin
                rx_data <= sh;
                rx_full <= 1'b1;
                if (rx_full && !bus.rd) overrun <= 1'b1;
                else if (bus.rd)        overrun <= 1'b0;
            end else if (bus.rd) begin
                rx_full <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

    uart_tx_ser #(
        .BIT_CYC   (BIT_CYC),
        .TIM_WIDTH (TIM_WIDTH)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .wr    (bus.wr),
        .data  (bus.tx_data),
        .tx    (tx),
        .ready (bus.tx_ready)
    );
endmodule

// File: tb/tb_uart_img_link.sv
`timescale 1ns/1ps
// tb_uart_img_link: randomized self-checking bench for uart_img_link.
// Byte-level preamble model; line waveforms generated bit by bit.
module tb_uart_img_link;
    localparam int BIT = 234;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;
    uart_img_link_if bus ();

    uart_img_link #(
        .CLOCK_HZ  (27_000_000),
        .BAUD      (115200),
        .TIM_WIDTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .tx  (tx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;
    int cyc  = 0;
    int img_cnt = 0, img_bad = 0, fe_cnt = 0;
    int t_start = 0, t_full = 0;
    bit full_prev = 1'b0;

    // Reference model of the detector, at byte granularity.
    bit armed = 1'b1;
    int prev  = -1;

    function automatic bit model_byte(input logic [7:0] b, input bit ok);
        bit h = 1'b0;
        if (!ok) begin
            armed = 1'b1;
            prev  = -1;
            return 1'b0;
        end
        if (armed && prev == 32'h55 && b == 8'hAA) begin
            h     = 1'b1;
            armed = 1'b0;
        end
        prev = int'(b);
        return h;
    endfunction

    function automatic void model_end();
        if (!armed) begin
            armed = 1'b1;
            prev  = -1;
        end
    endfunction

    always @(posedge clk) cyc++;

    // Event monitor: pulse counts and rx_full rising time.
    always @(negedge clk) begin
        if (bus.img_recv) begin
            img_cnt++;
            if (!(bus.rx_full && !full_prev && bus.rx_data == 8'hAA))
                img_bad++;
        end
        if (bus.frame_err) fe_cnt++;
        if (bus.rx_full && !full_prev) t_full = cyc;
        full_prev = bus.rx_full;
    end

    initial begin
        #(98_000 * 10);
        $display("FAIL watchdog: cycle limit reached");
        $fatal(1, "timeout");
    end

    task automatic send_rx(input logic [7:0] b, input bit ok);
        rx = 1'b0;
        t_start = cyc;
        repeat (BIT) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
        if (ok) begin
            rx = 1'b1;
            repeat (BIT) @(posedge clk);
        end else begin
            rx = 1'b0;
            repeat (160) @(posedge clk);
            #1;
            rx = 1'b1;
            repeat (BIT - 160) @(posedge clk);
        end
        #1;
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] b, input bit ok,
                        output bit hit, output int dimg, output int dfe);
        int i0, f0;
        hit = model_byte(b, ok);
        i0 = img_cnt;
        f0 = fe_cnt;
        send_rx(b, ok);
        dimg = img_cnt - i0;
        dfe  = fe_cnt - f0;
    endtask

    task automatic consume();
        bus.rd = 1'b1;
        @(posedge clk);
        #1;
        bus.rd = 1'b0;
    endtask

    task automatic end_pulse();
        bus.end_img_recv = 1'b1;
        @(posedge clk);
        #1;
        bus.end_img_recv = 1'b0;
        model_end();
    endtask

    task automatic test_reset();
        repeat (5) @(posedge clk);
        #1;
        vec++; if (tx !== 1'b1) begin errs++; $display("FAIL rst_tx got %0b exp 1", tx); end
        vec++; if (bus.tx_ready !== 1'b1) begin errs++; $display("FAIL rst_tx_ready got %0b exp 1", bus.tx_ready); end
        vec++; if (bus.rx_full !== 1'b0) begin errs++; $display("FAIL rst_rx_full got %0b exp 0", bus.rx_full); end
        vec++; if (bus.rx_data !== 8'h00) begin errs++; $display("FAIL rst_rx_data got %h exp 00", bus.rx_data); end
        vec++; if (bus.overrun !== 1'b0) begin errs++; $display("FAIL rst_overrun got %0b exp 0", bus.overrun); end
        vec++; if (bus.frame_err !== 1'b0) begin errs++; $display("FAIL rst_frame_err got %0b exp 0", bus.frame_err); end
        vec++; if (bus.img_recv !== 1'b0) begin errs++; $display("FAIL rst_img_recv got %0b exp 0", bus.img_recv); end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_rx_basic();
        bit hit; int dimg, dfe, lat;
        xfer(8'hA5, 1'b1, hit, dimg, dfe);
        lat = t_full - t_start;
        vec++; if (bus.rx_full !== 1'b1) begin errs++; $display("FAIL basic_full got %0b exp 1", bus.rx_full); end
        vec++; if (bus.rx_data !== 8'hA5) begin errs++; $display("FAIL basic_data got %h exp a5", bus.rx_data); end
        vec++; if (lat < 9 * BIT + BIT / 2 - 4 || lat > 10 * BIT + 2) begin
            errs++; $display("FAIL basic_latency got %0d exp %0d..%0d", lat, 9 * BIT + BIT / 2 - 4, 10 * BIT + 2);
        end
        vec++; if (dimg !== int'(hit)) begin errs++; $display("FAIL basic_img got %0d exp %0d", dimg, hit); end
        consume();
        vec++; if (bus.rx_full !== 1'b0) begin errs++; $display("FAIL basic_rd_clear got %0b exp 0", bus.rx_full); end
    endtask

    task automatic test_preamble();
        int items[$] = '{32'h12, 32'h55, 32'hAA, 32'h55, 32'hAA, 32'h100,
                         32'h55, 32'hAA, 32'h100, 32'h55, 32'h55, 32'hAA,
                         32'h100, 32'h55, 32'h00, 32'hAA};
        int i0 = img_cnt;
        foreach (items[k]) begin
            bit hit; int dimg, dfe;
            logic [7:0] b;
            if (items[k] > 255) begin
                end_pulse();
            end else begin
                b = 8'(items[k]);
                xfer(b, 1'b1, hit, dimg, dfe);
                vec++; if (bus.rx_full !== 1'b1) begin errs++; $display("FAIL pre_full[%0d] got %0b exp 1", k, bus.rx_full); end
                vec++; if (bus.rx_data !== b) begin errs++; $display("FAIL pre_data[%0d] got %h exp %h", k, bus.rx_data, b); end
                vec++; if (dimg !== int'(hit)) begin errs++; $display("FAIL pre_img[%0d] got %0d exp %0d", k, dimg, hit); end
                consume();
            end
        end
        vec++; if (img_cnt - i0 !== 3) begin errs++; $display("FAIL pre_total got %0d exp 3", img_cnt - i0); end
        vec++; if (img_bad !== 0) begin errs++; $display("FAIL pre_coincident got %0d exp 0", img_bad); end
    endtask

    task automatic test_frame();
        bit hit; int dimg, dfe, i0;
        xfer(8'h3C, 1'b0, hit, dimg, dfe);
        vec++; if (dfe !== 1) begin errs++; $display("FAIL fe_pulse got %0d exp 1", dfe); end
        vec++; if (bus.rx_full !== 1'b0) begin errs++; $display("FAIL fe_full got %0b exp 0", bus.rx_full); end
        i0 = img_cnt;
        xfer(8'h55, 1'b1, hit, dimg, dfe);
        consume();
        xfer(8'hAA, 1'b1, hit, dimg, dfe);
        vec++; if (bus.rx_data !== 8'hAA) begin errs++; $display("FAIL fe_aa_data got %h exp aa", bus.rx_data); end
        consume();
        vec++; if (img_cnt - i0 !== 1) begin errs++; $display("FAIL fe_then_pre got %0d exp 1", img_cnt - i0); end
        i0 = fe_cnt;
        rx = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        vec++; if (bus.rx_full !== 1'b0) begin errs++; $display("FAIL glitch_full got %0b exp 0", bus.rx_full); end
        vec++; if (fe_cnt !== i0) begin errs++; $display("FAIL glitch_fe got %0d exp %0d", fe_cnt, i0); end
    endtask

    task automatic test_overrun();
        bit hit; int dimg, dfe;
        xfer(8'h31, 1'b1, hit, dimg, dfe);
        vec++; if (bus.overrun !== 1'b0) begin errs++; $display("FAIL ovr_first got %0b exp 0", bus.overrun); end
        xfer(8'h42, 1'b1, hit, dimg, dfe);
        vec++; if (bus.overrun !== 1'b1) begin errs++; $display("FAIL ovr_set got %0b exp 1", bus.overrun); end
        vec++; if (bus.rx_data !== 8'h42) begin errs++; $display("FAIL ovr_data got %h exp 42", bus.rx_data); end
        consume();
        vec++; if (bus.overrun !== 1'b0) begin errs++; $display("FAIL ovr_clear got %0b exp 0", bus.overrun); end
        vec++; if (bus.rx_full !== 1'b0) begin errs++; $display("FAIL ovr_full_clear got %0b exp 0", bus.rx_full); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            bit hit; int dimg, dfe, r;
            logic [7:0] b;
            if ($urandom_range(0, 4) == 0) end_pulse();
            r = int'($urandom_range(0, 3));
            if (r == 1)      b = 8'hAA;
            else if (r == 2) b = 8'($urandom);
            else             b = 8'h55;
            xfer(b, 1'b1, hit, dimg, dfe);
            vec++; if (bus.rx_data !== b) begin errs++; $display("FAIL rnd_data[%0d] got %h exp %h", n, bus.rx_data, b); end
            vec++; if (dimg !== int'(hit)) begin errs++; $display("FAIL rnd_img[%0d] got %0d exp %0d", n, dimg, hit); end
            consume();
        end
    endtask

    task automatic test_tx();
        logic [7:0] b = 8'h5A;
        logic [7:0] b2 = 8'hC3;
        logic [9:0] exp;
        int w;
        exp = {1'b1, b, 1'b0};
        bus.tx_data = b;
        bus.wr = 1'b1;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        bus.tx_data = 8'h00;
        vec++; if (bus.tx_ready !== 1'b0) begin errs++; $display("FAIL tx_busy got %0b exp 0", bus.tx_ready); end
        for (int k = 0; k < 10; k++) begin
            repeat (BIT / 2) @(posedge clk);
            #1;
            vec++; if (tx !== exp[k]) begin errs++; $display("FAIL tx_bit[%0d] got %0b exp %0b", k, tx, exp[k]); end
            if (k == 3) begin
                bus.tx_data = 8'hFF;
                bus.wr = 1'b1;
                @(posedge clk);
                #1;
                bus.wr = 1'b0;
                repeat (BIT / 2 - 1) @(posedge clk);
            end else begin
                repeat (BIT / 2) @(posedge clk);
            end
            #1;
        end
        w = 0;
        while (bus.tx_ready !== 1'b1 && w < 3) begin
            @(posedge clk);
            #1;
            w++;
        end
        vec++; if (bus.tx_ready !== 1'b1) begin errs++; $display("FAIL tx_ready_end got %0b exp 1", bus.tx_ready); end
        bus.tx_data = b2;
        bus.wr = 1'b1;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        vec++; if (tx !== 1'b0) begin errs++; $display("FAIL b2b_start got %0b exp 0", tx); end
        repeat (BIT + BIT / 2) @(posedge clk);
        #1;
        vec++; if (tx !== b2[0]) begin errs++; $display("FAIL b2b_bit0 got %0b exp %0b", tx, b2[0]); end
        rst = 1'b1;
        #1;
        vec++; if (tx !== 1'b1) begin errs++; $display("FAIL rst_mid_tx got %0b exp 1", tx); end
        vec++; if (bus.tx_ready !== 1'b1) begin errs++; $display("FAIL rst_mid_ready got %0b exp 1", bus.tx_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        armed = 1'b1;
        prev  = -1;
    endtask

    initial begin
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        bus.tx_data = 8'h00;
        bus.end_img_recv = 1'b0;
        test_reset();
        test_rx_basic();
        test_preamble();
        test_frame();
        test_overrun();
        test_random();
        test_tx();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
